// File: rtl/any1_alu_issue_queue_if.sv
// Record types and issue-side interface for the ANY1 ALU issue queue.
// master = dispatch/ALU side, slave = the queue itself.
package any1_aluq_pkg;

  // 359-bit ALU issue record
  typedef struct packed {
    logic        wr;
    logic [5:0]  rid;
    logic [31:0] ir;
    logic [63:0] pc;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] imm;
  } salu_rec_t;

  typedef struct packed {
    logic        wr;
    logic [5:0]  rid;
    logic [63:0] pc;
  } sredirect_t;

endpackage

interface any1_alu_issue_queue_if #(
  parameter int DEPTH = 8
);
  import any1_aluq_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  salu_rec_t   alu_i;
  sredirect_t  redirect_i;
  salu_rec_t   q_o;
  logic        vld_o;
  logic        rdy_i;
  logic        full_o;
  logic        afull_o;
  logic [CW-1:0] cnt_o;
  logic        ovf_o;

  modport master (
    output alu_i, redirect_i, rdy_i,
    input  q_o, vld_o, full_o, afull_o, cnt_o, ovf_o
  );

  modport slave (
    input  alu_i, redirect_i, rdy_i,
    output q_o, vld_o, full_o, afull_o, cnt_o, ovf_o
  );

endinterface

// File: rtl/any1_alu_issue_queue.sv
// In-order issue queue feeding one ALU over valid/ready; redirect flushes everything.
// Optional same-cycle empty bypass: define ANY1_ALUQ_BYPASS_EN.
module any1_alu_issue_queue
  import any1_aluq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  any1_alu_issue_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  salu_rec_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic not_empty;
  logic flush;
  logic pop;
  logic room;
  logic bypass;
  logic push;
  logic drop;
  logic redirect_unused;

  assign not_empty = (count != '0);
  assign flush     = bus.redirect_i.wr;
  assign pop       = not_empty & bus.rdy_i & ~flush;
  assign room      = (count != CW'(DEPTH)) | pop;

`ifdef ANY1_ALUQ_BYPASS_EN
  // An empty queue with a ready ALU hands the incoming record straight through.
  assign bypass = ~not_empty & bus.alu_i.wr & bus.rdy_i & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = bus.alu_i.wr & ~flush & room & ~bypass;
  assign drop = bus.alu_i.wr & ~flush & ~room;

  // Only the flush strobe matters here; the redirect target is for fetch.
  assign redirect_unused = ^{bus.redirect_i.rid, bus.redirect_i.pc};

  // NOTE: the record storage has no reset; its contents are only observed
  // through count-qualified reads, so resetting it would only cost flops.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= bus.alu_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= drop;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the combinational head mux assigns a default first so no path
  // through the block can leave the output unassigned (no latch).
  always_comb begin
    salu_rec_t q;
    q = '0;
    if (not_empty) q = mem[rd_ptr];
`ifdef ANY1_ALUQ_BYPASS_EN
    if (bypass) q = bus.alu_i;
`endif
    q.wr    = not_empty | bypass;
    bus.q_o = q;
  end

  assign bus.vld_o   = not_empty | bypass;
  assign bus.cnt_o   = count;
  assign bus.full_o  = (count == CW'(DEPTH));
  assign bus.afull_o = (count >= CW'(AFULL_LVL));
  assign bus.ovf_o   = ovf;

endmodule

// File: tb/tb_any1_alu_issue_queue.sv
// Randomised bench for any1_alu_issue_queue against a queue-based model;
// build with ANY1_ALUQ_BYPASS_EN defined to cover the bypass variant.
module tb_any1_alu_issue_queue;
  import any1_aluq_pkg::*;

  localparam int DEPTH     = 8;
  localparam int AFULL_LVL = 6;
  localparam int RW        = $bits(salu_rec_t);
`ifdef ANY1_ALUQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  any1_alu_issue_queue_if #(.DEPTH(DEPTH)) bus ();

  any1_alu_issue_queue #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  salu_rec_t  mq[$];
  bit         m_ovf = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;
  bit         cmp_en = 1'b0;
  logic [5:0] rid = 6'd0;

  task automatic check(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic salu_rec_t make_rec(logic [5:0] r);
    salu_rec_t x;
    x.wr  = 1'b1;
    x.rid = r;
    x.ir  = $urandom;
    x.pc  = {$urandom, $urandom};
    x.a   = {$urandom, $urandom};
    x.b   = {$urandom, $urandom};
    x.c   = {$urandom, $urandom};
    x.imm = {$urandom, $urandom};
    return x;
  endfunction

  // Record handed straight through this cycle (bypass build only)
  function automatic bit m_bypass();
    return BYP && mq.size() == 0 && bus.alu_i.wr && bus.rdy_i && !bus.redirect_i.wr;
  endfunction

  task automatic model_step();
    int sz;
    bit pop;
    if (bus.redirect_i.wr) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (m_bypass()) begin
      m_ovf = 1'b0;
    end else begin
      sz  = mq.size();
      pop = (sz != 0) && bus.rdy_i;
      if (pop) void'(mq.pop_front());
      m_ovf = 1'b0;
      if (bus.alu_i.wr) begin
        if (sz < DEPTH || pop) mq.push_back(bus.alu_i);
        else m_ovf = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk_i) begin
    if (cmp_en) begin
      salu_rec_t eq;
      bit ev;
      ev = (mq.size() != 0) || m_bypass();
      eq = '0;
      if (m_bypass()) eq = bus.alu_i;
      else if (mq.size() != 0) eq = mq[0];
      eq.wr = ev;
      check("vld",   RW'(bus.vld_o),   RW'(ev));
      check("q",     bus.q_o,          eq);
      check("cnt",   RW'(bus.cnt_o),   RW'(mq.size()));
      check("full",  RW'(bus.full_o),  RW'(mq.size() == DEPTH));
      check("afull", RW'(bus.afull_o), RW'(mq.size() >= AFULL_LVL));
      check("ovf",   RW'(bus.ovf_o),   RW'(m_ovf));
    end
  end

  task automatic cyc(bit wr, logic [5:0] r, bit rdy, bit fl);
    @(posedge clk_i);
    #1;
    bus.alu_i         = wr ? make_rec(r) : '0;
    bus.rdy_i         = rdy;
    bus.redirect_i    = '0;
    bus.redirect_i.wr = fl;
    if (fl) bus.redirect_i.pc = {$urandom, $urandom};
  endtask

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      cyc(($urandom % 4) != 0, rid, $urandom % 2, ($urandom % 50) == 0);
      rid++;
    end
  endtask

  initial begin
    bus.alu_i      = '0;
    bus.redirect_i = '0;
    bus.rdy_i      = 1'b0;
    cmp_en         = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("rst_cnt", RW'(bus.cnt_o), RW'(0));
    check("rst_vld", RW'(bus.vld_o), RW'(0));
    check("rst_q",   bus.q_o, '0);

    // In-order fill and drain
    cyc(1, 6'd1, 0, 0); cyc(1, 6'd2, 0, 0); cyc(1, 6'd3, 0, 0); cyc(0, 0, 0, 0);
    check("t1_cnt", RW'(bus.cnt_o), RW'(3));
    check("t1_rid", RW'(bus.q_o.rid), RW'(1));
    cyc(0, 0, 0, 0);
    check("t1_rid_stable", RW'(bus.q_o.rid), RW'(1));
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    check("t1_vld_end", RW'(bus.vld_o), RW'(0));
    check("t1_cnt_end", RW'(bus.cnt_o), RW'(0));

    // Fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 6'(10 + i), 0, 0);
      if (i == 5) check("t2_afull_5", RW'(bus.afull_o), RW'(0));
      if (i == 6) check("t2_afull_6", RW'(bus.afull_o), RW'(1));
    end
    cyc(1, 6'd18, 0, 0);
    check("t2_full", RW'(bus.full_o), RW'(1));
    check("t2_cnt8", RW'(bus.cnt_o), RW'(8));
    cyc(0, 0, 0, 0);
    check("t2_ovf",  RW'(bus.ovf_o), RW'(1));
    check("t2_head", RW'(bus.q_o.rid), RW'(10));
    cyc(0, 0, 0, 0);
    check("t2_ovf_clr", RW'(bus.ovf_o), RW'(0));

    // Full with simultaneous push and pop
    cyc(1, 6'd30, 1, 0); cyc(0, 0, 0, 0);
    check("t3_cnt",  RW'(bus.cnt_o), RW'(8));
    check("t3_ovf",  RW'(bus.ovf_o), RW'(0));
    check("t3_head", RW'(bus.q_o.rid), RW'(11));
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 1, 0);
      if (i == DEPTH - 1) check("t3_last", RW'(bus.q_o.rid), RW'(30));
    end
    cyc(0, 0, 0, 0);
    check("t3_empty", RW'(bus.cnt_o), RW'(0));

    // Flush beats a same-cycle write and pop
    for (int i = 0; i < 5; i++) cyc(1, 6'(41 + i), 0, 0);
    cyc(1, 6'd46, 1, 1);
    check("t4_cnt5", RW'(bus.cnt_o), RW'(5));
    cyc(0, 0, 0, 0);
    check("t4_cnt0", RW'(bus.cnt_o), RW'(0));
    check("t4_vld0", RW'(bus.vld_o), RW'(0));
    check("t4_ovf0", RW'(bus.ovf_o), RW'(0));
    cyc(1, 6'd47, 0, 0); cyc(0, 0, 0, 0);
    check("t4_rid", RW'(bus.q_o.rid), RW'(47));
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);

    // Empty write with ready: bypass vs one-cycle fall-through
    cyc(1, 6'd9, 1, 0);
    check("t6_vld_now", RW'(bus.vld_o), RW'(BYP));
    check("t6_rid_now", RW'(bus.q_o.rid), BYP ? RW'(9) : RW'(0));
    cyc(0, 0, 0, 0);
    check("t6_cnt_next", RW'(bus.cnt_o), BYP ? RW'(0) : RW'(1));
    check("t6_vld_next", RW'(bus.vld_o), BYP ? RW'(0) : RW'(1));
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);

    rand_run(400);

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 4; i++) cyc(1, 6'(50 + i), 0, 0);
    @(posedge clk_i);
    #1;
    rst_i          = 1'b1;
    bus.alu_i      = '0;
    bus.redirect_i = '0;
    bus.rdy_i      = 1'b0;
    #1;
    check("arst_cnt", RW'(bus.cnt_o), RW'(0));
    check("arst_vld", RW'(bus.vld_o), RW'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    rand_run(200);
    cyc(0, 0, 0, 0);
    @(negedge clk_i);
    #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
